// File: rtl/pipe_skid_register.sv
// Two-entry pipeline register: main entry M drives the output, skid entry S absorbs
// the one payload accepted while M is stalled, so in_ready never depends on out_ready.
module pipe_skid_register #(
  parameter int unsigned            WIDTH  = 64,
  parameter logic [WIDTH-1:0]       BUBBLE = '0,
  parameter int unsigned            CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             mv_q, mv_d;
  logic             sv_q, sv_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic accept;
  logic release_m;

  assign in_ready  = ~sv_q & ~flush;
  assign accept    = in_valid & in_ready;
  assign release_m = mv_q & out_ready;

  assign out_valid = mv_q;
  assign out_data  = mv_q ? m_q : BUBBLE;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    m_d  = m_q;
    s_d  = s_q;
    mv_d = mv_q;
    sv_d = sv_q;
    if (flush) begin
      mv_d = 1'b0;
      sv_d = 1'b0;
    end else if (!mv_q || release_m) begin
      // M is free this edge: refill from skid first to keep acceptance order.
      if (sv_q) begin
        m_d  = s_q;
        mv_d = 1'b1;
        sv_d = 1'b0;
      end else if (accept) begin
        m_d  = in_data;
        mv_d = 1'b1;
      end else begin
        mv_d = 1'b0;
      end
    end else if (accept) begin
      s_d  = in_data;
      sv_d = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_stats) begin
      stall_cnt_d = '0;
    end else if (mv_q && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q         <= '0;
      s_q         <= '0;
      mv_q        <= 1'b0;
      sv_q        <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      m_q         <= m_d;
      s_q         <= s_d;
      mv_q        <= mv_d;
      sv_q        <= sv_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
